// File: rtl/bus_rr_arbiter_pkg.sv
// rtl/bus_rr_arbiter_pkg.sv - shared constants, state type and round-robin search for the four-master bus
package bus_rr_arbiter_pkg;

    localparam int BUS_MASTER_CNT = 4;

    typedef logic [1:0] bus_owner_t;

    localparam bus_owner_t BUS_OWNER_M0 = 2'h0;
    localparam bus_owner_t BUS_OWNER_M1 = 2'h1;
    localparam bus_owner_t BUS_OWNER_M2 = 2'h2;
    localparam bus_owner_t BUS_OWNER_M3 = 2'h3;

    localparam logic ASSERTED_L   = 1'b0;
    localparam logic DEASSERTED_L = 1'b1;

    typedef enum logic {
        BUS_ARB_STATE_IDLE = 1'b0,
        BUS_ARB_STATE_BUSY = 1'b1
    } bus_arb_state_t;

    // Search ptr+1, ptr+2, ptr+3, ptr (mod 4); returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [BUS_MASTER_CNT-1:0] req,
                                           input bus_owner_t ptr);
        logic       found;
        bus_owner_t idx;
        bus_owner_t cand;
        found = 1'b0;
        idx   = BUS_OWNER_M0;
        for (int k = 1; k <= BUS_MASTER_CNT; k++) begin
            cand = bus_owner_t'(ptr + bus_owner_t'(k));
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/bus_rr_arbiter_timeout.sv
// rtl/bus_rr_arbiter_timeout.sv - bus_timeout: slave-access watchdog forcing ready after a stall
module bus_timeout
    import bus_rr_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       sAs_,
    input  logic       sRdy_,
    input  logic [1:0] owner,
    input  logic       toClr,
    output logic       toRdy_,
    output logic       toIrq,
    output logic [1:0] toMaster
);

    localparam int RAW_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW    = (RAW_W > 8) ? RAW_W : 8;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          stall;
    logic          fire;

    // A stall is a strobed access with ready still high; it fires on the sample that would reach the limit.
    assign stall = (sAs_ == ASSERTED_L) && (sRdy_ == DEASSERTED_L);
    assign fire  = stall && (cnt == LAST);

    // Stall counter, one-cycle forced ready, sticky interrupt (set beats clear) and owner capture.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            cnt      <= '0;
            toRdy_   <= DEASSERTED_L;
            toIrq    <= 1'b0;
            toMaster <= BUS_OWNER_M0;
        end else begin
            cnt    <= (stall && !fire) ? cnt + 1'b1 : '0;
            toRdy_ <= fire ? ASSERTED_L : DEASSERTED_L;
            if (fire) begin
                toIrq    <= 1'b1;
                toMaster <= owner;
            end else if (toClr) begin
                toIrq <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// rtl/bus_rr_arbiter.sv - four-master round-robin bus arbiter; optional watchdog under BUS_TIMEOUT_EN
module bus_rr_arbiter
    import bus_rr_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       m0Req_,
    input  logic       m1Req_,
    input  logic       m2Req_,
    input  logic       m3Req_,
    output logic       m0Grnt_,
    output logic       m1Grnt_,
    output logic       m2Grnt_,
    output logic       m3Grnt_,
    output logic [1:0] owner,
    input  logic       sAs_,
    input  logic       sRdy_,
    output logic       toRdy_,
    output logic       toIrq,
    output logic [1:0] toMaster,
    input  logic       toClr
);

    bus_arb_state_t            state, state_nxt;
    bus_owner_t                last_ptr, last_nxt;
    bus_owner_t                owner_q, owner_nxt;
    logic [BUS_MASTER_CNT-1:0] gnt_q, gnt_nxt;
    logic [BUS_MASTER_CNT-1:0] req;
    logic                      found;
    bus_owner_t                pick;

    assign req = ~{m3Req_, m2Req_, m1Req_, m0Req_};

    // Registered state, pointer, owner and one-hot grant; lastPtr=3 gives M0 first priority.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state    <= BUS_ARB_STATE_IDLE;
            last_ptr <= BUS_OWNER_M3;
            owner_q  <= BUS_OWNER_M0;
            gnt_q    <= '0;
        end else begin
            state    <= state_nxt;
            last_ptr <= last_nxt;
            owner_q  <= owner_nxt;
            gnt_q    <= gnt_nxt;
        end
    end

    // Grant from IDLE, hold while owner requests, hand over or drop to IDLE on release.
    always_comb begin
        state_nxt     = state;
        last_nxt      = last_ptr;
        owner_nxt     = owner_q;
        gnt_nxt       = gnt_q;
        {found, pick} = rr_pick(req, last_ptr);
        case (state)
            BUS_ARB_STATE_IDLE: begin
                if (found) begin
                    state_nxt = BUS_ARB_STATE_BUSY;
                    last_nxt  = pick;
                    owner_nxt = pick;
                    gnt_nxt   = 4'(4'b0001 << pick);
                end
            end
            BUS_ARB_STATE_BUSY: begin
                // The releasing owner's request is high, so the search naturally skips it.
                if (!req[owner_q]) begin
                    if (found) begin
                        last_nxt  = pick;
                        owner_nxt = pick;
                        gnt_nxt   = 4'(4'b0001 << pick);
                    end else begin
                        state_nxt = BUS_ARB_STATE_IDLE;
                        gnt_nxt   = '0;
                    end
                end
            end
            default: begin
                state_nxt = BUS_ARB_STATE_IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    assign m0Grnt_ = ~gnt_q[0];
    assign m1Grnt_ = ~gnt_q[1];
    assign m2Grnt_ = ~gnt_q[2];
    assign m3Grnt_ = ~gnt_q[3];
    assign owner   = owner_q;

`ifdef BUS_TIMEOUT_EN
    bus_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .reset_   (reset_),
        .sAs_     (sAs_),
        .sRdy_    (sRdy_),
        .owner    (owner_q),
        .toClr    (toClr),
        .toRdy_   (toRdy_),
        .toIrq    (toIrq),
        .toMaster (toMaster)
    );
`else
    logic unused_watchdog_inputs;
    assign unused_watchdog_inputs = &{1'b0, sAs_, sRdy_, toClr};
    assign toRdy_   = DEASSERTED_L;
    assign toIrq    = 1'b0;
    assign toMaster = BUS_OWNER_M0;
`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb/tb_bus_rr_arbiter.sv - scoreboard bench for bus_rr_arbiter with a behavioural arbitration model
module tb_bus_rr_arbiter;

    localparam int T = 4;

    typedef struct packed {
        logic [3:0] gnt_n;
        logic [1:0] own;
        logic       rdy_n;
        logic       irq;
        logic [1:0] tom;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_;
    logic [3:0] req_n;
    logic       sAs_, sRdy_, toClr;
    logic       m0Grnt_, m1Grnt_, m2Grnt_, m3Grnt_;
    logic [1:0] owner, toMaster;
    logic       toRdy_, toIrq;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t q[$];

    bit m_busy;
    int m_owner, m_last, m_cnt;
    bit m_rdy_n, m_irq;
    int m_tom;

    bus_rr_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset_(reset_),
        .m0Req_(req_n[0]), .m1Req_(req_n[1]), .m2Req_(req_n[2]), .m3Req_(req_n[3]),
        .m0Grnt_(m0Grnt_), .m1Grnt_(m1Grnt_), .m2Grnt_(m2Grnt_), .m3Grnt_(m3Grnt_),
        .owner(owner), .sAs_(sAs_), .sRdy_(sRdy_),
        .toRdy_(toRdy_), .toIrq(toIrq), .toMaster(toMaster), .toClr(toClr)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] dut_gnt();
        return {m3Grnt_, m2Grnt_, m1Grnt_, m0Grnt_};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_last = 3; m_cnt = 0;
        m_rdy_n = 1; m_irq = 0; m_tom = 0;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.gnt_n = m_busy ? ~(4'b0001 << m_owner) : 4'hF;
        e.own   = 2'(m_owner);
        e.rdy_n = m_rdy_n;
        e.irq   = m_irq;
        e.tom   = 2'(m_tom);
        return e;
    endfunction

    // One clock edge of the specified behaviour, from the inputs present before the edge.
    task automatic model_step();
        bit r[4];
        bit stall;
        int pick;
        for (int i = 0; i < 4; i++) r[i] = (req_n[i] == 1'b0);
`ifdef BUS_TIMEOUT_EN
        stall = (sAs_ == 1'b0) && (sRdy_ == 1'b1);
        if (stall && m_cnt + 1 == T) begin
            m_rdy_n = 0; m_irq = 1; m_tom = m_owner; m_cnt = 0;
        end else begin
            m_rdy_n = 1;
            m_cnt = stall ? m_cnt + 1 : 0;
            if (toClr) m_irq = 0;
        end
`else
        stall = 0;
        m_rdy_n = 1; m_irq = 0; m_tom = 0; m_cnt = stall ? 1 : 0;
`endif
        if (!(m_busy && r[m_owner])) begin
            pick = -1;
            for (int k = 1; k <= 4; k++)
                if (pick < 0 && r[(m_last + k) % 4]) pick = (m_last + k) % 4;
            if (pick >= 0) begin
                m_busy = 1; m_owner = pick; m_last = pick;
            end else begin
                m_busy = 0;
            end
        end
    endtask

    // Advance one edge, queue the expected outputs, and return #1 after the edge.
    task automatic cycle();
        @(posedge clk);
        if (!reset_) model_reset();
        else model_step();
        q.push_back(model_out());
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        reset_ = 1'b0;
        model_reset();
        q.delete();
        cycles(2);
        reset_ = 1'b1;
    endtask

    // Monitor: compare every registered output against the queued expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e, a;
            e = q.pop_front();
            a = {dut_gnt(), owner, toRdy_, toIrq, toMaster};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL scoreboard: got gnt_n=%b own=%0d rdy_n=%b irq=%b tom=%0d expected gnt_n=%b own=%0d rdy_n=%b irq=%b tom=%0d at %0t",
                         a.gnt_n, a.own, a.rdy_n, a.irq, a.tom, e.gnt_n, e.own, e.rdy_n, e.irq, e.tom, $time);
            end
            n_checks++;
            if ($countones(~a.gnt_n) > 1) begin
                n_fail++;
                $display("FAIL one_grant: got gnt_n=%b expected at most one low at %0t", a.gnt_n, $time);
            end
        end
    end

    int order[5] = '{0, 1, 2, 3, 0};

    initial begin
        req_n = 4'hF; sAs_ = 1'b1; sRdy_ = 1'b1; toClr = 1'b0;
        reset_ = 1'b0;
        model_reset();
        cycles(2);
        reset_ = 1'b1;
        chk("reset_grants", dut_gnt(), 4'hF);
        chk("reset_owner", owner, 0);

        // M0 and M2 together, then direct handover from M0 to M2.
        req_n = 4'b1010;
        cycle();
        chk("first_grant_m0", dut_gnt(), 4'b1110);
        cycle();
        req_n = 4'b1011;
        cycle();
        chk("handover_m2", dut_gnt(), 4'b1011);
        chk("handover_owner", owner, 2);
        req_n = 4'hF;
        cycles(2);

        // All four requesting, each owner releasing after three cycles.
        do_reset();
        req_n = 4'h0;
        cycle();
        chk("rr_order_0", owner, order[0]);
        for (int n = 1; n < 5; n++) begin
            cycles(2);
            req_n[order[n-1]] = 1'b1;
            cycle();
            chk($sformatf("rr_order_%0d", n), owner, order[n]);
            req_n[order[n-1]] = 1'b0;
        end
        req_n = 4'hF;
        cycles(2);

        // M1 alone, release, request again two cycles later.
        req_n = 4'b1101;
        cycles(3);
        req_n = 4'hF;
        cycle();
        chk("m1_idle_gap", dut_gnt(), 4'hF);
        cycle();
        req_n = 4'b1101;
        cycle();
        chk("m1_regrant", dut_gnt(), 4'b1101);
        req_n = 4'hF;
        cycles(2);

        // Asynchronous reset while M3 owns the bus.
        req_n = 4'b0111;
        cycles(3);
        @(negedge clk);
        #2;
        reset_ = 1'b0;
        #1;
        chk("async_reset_grants", dut_gnt(), 4'hF);
        chk("async_reset_owner", owner, 0);
        model_reset();
        q.delete();
        req_n = 4'hF;
        cycle();
        reset_ = 1'b1;
        req_n = 4'h0;
        cycle();
        chk("post_reset_m0_wins", dut_gnt(), 4'b1110);
        req_n = 4'hF;
        cycles(2);

        // Watchdog: M2 owns the bus while the slave never returns ready.
        req_n = 4'b1011;
        cycle();
        sAs_ = 1'b0; sRdy_ = 1'b1;
        cycles(3);
        chk("wd_no_early", toRdy_, 1);
        cycle();
`ifdef BUS_TIMEOUT_EN
        chk("wd_fire_rdy", toRdy_, 0);
        chk("wd_fire_irq", toIrq, 1);
        chk("wd_fire_master", toMaster, 2);
`else
        chk("wd_off_rdy", toRdy_, 1);
        chk("wd_off_irq", toIrq, 0);
`endif
        sAs_ = 1'b1;
        cycle();
        chk("wd_one_cycle", toRdy_, 1);
        toClr = 1'b1;
        cycle();
        toClr = 1'b0;
        chk("wd_clr_irq", toIrq, 0);

        // Ready returns in the third stall cycle: count restarts, no timeout.
        sAs_ = 1'b0; sRdy_ = 1'b1;
        cycles(2);
        sRdy_ = 1'b0;
        cycle();
        sRdy_ = 1'b1;
        cycles(2);
        chk("wd_ready_saves_rdy", toRdy_, 1);
        chk("wd_ready_saves_irq", toIrq, 0);
        sAs_ = 1'b1;
        req_n = 4'hF;
        cycles(2);

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (m_busy && m_owner == i && req_n[i] == 1'b0)
                    req_n[i] = ($urandom_range(0, 3) == 0);
                else
                    req_n[i] = ($urandom_range(0, 2) != 0);
            end
            sAs_  = ($urandom_range(0, 4) == 0);
            sRdy_ = ($urandom_range(0, 5) != 0);
            toClr = ($urandom_range(0, 9) == 0);
            cycle();
        end

        req_n = 4'hF; sAs_ = 1'b1; toClr = 1'b0;
        cycles(2);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
